// File: rtl/reg_pkg.sv
// Shared types for the 8x16 register block write-back path.
package reg_pkg;

    localparam int REG_W    = 16;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]  reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    // Register 0 is hardwired to zero, so writes to it carry no effect.
    function automatic logic is_discard(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of write-back requests; head is visible combinationally so
// the output stage can capture it on the pop edge.
module wb_fifo
    import reg_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_req_t       push_data,
    input  logic          pop,
    output wb_req_t       head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap on their own.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back initiator: arbitrates load/ALU results into a FIFO, drains one
// write per cycle to the register block, and tracks pending writes per register.
module reg_writeback
    import reg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REG_W,
    parameter int AW    = REG_AW,
    localparam int NR  = 2 ** AW,
    localparam int CW  = $clog2(DEPTH + 1),
    localparam int PCW = $clog2(DEPTH + 2)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             MemValid,
    output logic             MemReady,
    input  logic [AW-1:0]    MemRw,
    input  logic [WIDTH-1:0] MemData,
    input  logic             AluValid,
    output logic             AluReady,
    input  logic [AW-1:0]    AluRw,
    input  logic [WIDTH-1:0] AluData,
    input  logic             Stall,
    output logic             We,
    output logic [AW-1:0]    Rw,
    output logic [WIDTH-1:0] WData,
    output logic [NR-1:0]    Pending,
    output logic [CW-1:0]    Count
);

    wb_req_t          push_req;
    wb_req_t          head;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             we_q, we_d;
    logic [AW-1:0]    rw_q, rw_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    assign MemReady = !full;
    assign AluReady = !full && !MemValid;

    always_comb begin
        push_req = '{addr: MemRw, data: MemData};
        accept   = MemValid && !full;
        if (!MemValid) begin
            push_req = '{addr: AluRw, data: AluData};
            accept   = AluValid && !full;
        end
        // Writes to register 0 are acknowledged but never enter the queue.
        push    = accept && !is_discard(push_req.addr);
        pop     = !empty && !Stall;
        we_d    = pop;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        if (pop) begin
            rw_d    = head.addr;
            wdata_d = head.data;
        end
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (Clock),
        .rst      (Reset),
        .push     (push),
        .push_data(push_req),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (Count)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            we_q    <= 1'b0;
            rw_q    <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
        end
    end

    assign We    = we_q;
    assign Rw    = rw_q;
    assign WData = wdata_q;

    // A register can have up to DEPTH queued writes plus one in the output stage.
    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign Pending[gi] = 1'b0;
            end else begin : g_cnt
                logic [PCW-1:0] cnt_q, cnt_d;
                logic           inc;
                logic           dec;

                always_comb begin
                    inc   = push && (push_req.addr == AW'(gi));
                    dec   = we_q && (rw_q == AW'(gi));
                    cnt_d = cnt_q + PCW'(inc) - PCW'(dec);
                end

                always_ff @(posedge Clock or posedge Reset) begin
                    if (Reset) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign Pending[gi] = (cnt_q != '0);
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised and directed bench for reg_writeback with a queue-based
// scoreboard and a behavioural register-block model.
module tb_reg_writeback;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        mem_valid, alu_valid, stall;
    logic [2:0]  mem_rw, alu_rw;
    logic [15:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic        we;
    logic [2:0]  rw;
    logic [15:0] wdata;
    logic [7:0]  pending;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    ent_t        exp_q[$];
    ent_t        inflight;
    bit          inflight_v = 0;
    int          fifo_cnt   = 0;
    bit          last_acc;
    logic [15:0] dut_regs   [8];
    logic [15:0] model_regs [8];

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .Clock   (clk),
        .Reset   (rst),
        .MemValid(mem_valid),
        .MemReady(mem_ready),
        .MemRw   (mem_rw),
        .MemData (mem_data),
        .AluValid(alu_valid),
        .AluReady(alu_ready),
        .AluRw   (alu_rw),
        .AluData (alu_data),
        .Stall   (stall),
        .We      (we),
        .Rw      (rw),
        .WData   (wdata),
        .Pending (pending),
        .Count   (count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register block: captures on the edge where We is high.
    always @(posedge clk) begin
        if (we === 1'b1) dut_regs[rw] <= wdata;
    end

    // Model commit of the write observed in the previous half-cycle.
    always @(posedge clk) begin
        if (inflight_v) begin
            model_regs[inflight.a] = inflight.d;
            inflight_v = 0;
        end
    end

    // Monitor: Pending reflects every accepted, not-yet-captured write; each We
    // pulse must match the oldest such write.
    always @(negedge clk) begin
        logic [7:0] ep;
        ent_t       h;
        if (rst) begin
            chk("reset_we", we, 1'b0);
            chk("reset_pending", pending, 8'h00);
        end else begin
            ep = 8'h00;
            foreach (exp_q[i]) ep[exp_q[i].a] = 1'b1;
            chk("pending", pending, ep);
            if (we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", we, 1'b0);
                end else begin
                    h = exp_q.pop_front();
                    chk("we_rw", rw, h.a);
                    chk("we_data", wdata, h.d);
                    inflight   = h;
                    inflight_v = 1;
                end
            end
        end
        $display("mon t=%0t we=%0b rw=%0d wdata=%h pending=%h count=%0d", $time, we, rw, wdata, pending, count);
    end

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic step(input logic mv, input logic [2:0] mrw, input logic [15:0] md,
                        input logic av, input logic [2:0] arw, input logic [15:0] ad,
                        input logic st);
        bit mem_acc, alu_acc, pop;
        int push;
        mem_valid = mv; mem_rw = mrw; mem_data = md;
        alu_valid = av; alu_rw = arw; alu_data = ad;
        stall = st;
        #1;
        chk("mem_ready", mem_ready, fifo_cnt != DEPTH);
        chk("alu_ready", alu_ready, (fifo_cnt != DEPTH) && !mv);
        chk("count", count, fifo_cnt);
        mem_acc  = mv && (fifo_cnt != DEPTH);
        alu_acc  = av && !mv && (fifo_cnt != DEPTH);
        last_acc = mem_acc || alu_acc;
        @(posedge clk);
        pop  = (fifo_cnt > 0) && !st;
        push = 0;
        if (mem_acc && mrw != 0) begin exp_q.push_back('{a: mrw, d: md}); push = 1; end
        if (alu_acc && arw != 0) begin exp_q.push_back('{a: arw, d: ad}); push = 1; end
        fifo_cnt = fifo_cnt + push - (pop ? 1 : 0);
        $display("drv t=%0t mv=%0b mrw=%0d av=%0b arw=%0d st=%0b acc=%0b model_cnt=%0d",
                 $time, mv, mrw, av, arw, st, last_acc, fifo_cnt);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin dut_regs[i] = '0; model_regs[i] = '0; end
        rst = 1; mem_valid = 0; alu_valid = 0; stall = 0;
        mem_rw = 0; alu_rw = 0; mem_data = 0; alu_data = 0;
        #2;
        chk("rst_we", we, 1'b0);
        chk("rst_pending", pending, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_rw", rw, 0);
        chk("rst_wdata", wdata, 0);
        mem_valid = 1; #1;
        chk("rst_alu_ready_memvalid", alu_ready, 1'b0);
        mem_valid = 0; #1;
        chk("rst_alu_ready_idle", alu_ready, 1'b1);
        @(negedge clk); @(negedge clk); #1;
        rst = 0;
        idle(2);

        // Single ALU write: latency of Pending and We.
        step(0, 0, 0, 1, 5, 16'hBEEF, 0);
        chk("beef_pending_k", pending[5], 1'b1);
        chk("beef_we_k", we, 1'b0);
        idle(1);
        chk("beef_we", we, 1'b1);
        chk("beef_rw", rw, 5);
        chk("beef_wdata", wdata, 16'hBEEF);
        idle(1);
        chk("beef_reg", dut_regs[5], 16'hBEEF);
        chk("beef_pending_clr", pending[5], 1'b0);
        chk("beef_we_one_cycle", we, 1'b0);

        // Simultaneous Mem and ALU to the same register: Mem wins first.
        step(1, 2, 16'h1111, 1, 2, 16'h2222, 0);
        step(0, 0, 0, 1, 2, 16'h2222, 0);
        idle(4);
        chk("pair_reg2", dut_regs[2], 16'h2222);

        // Write to register 0 is discarded.
        step(1, 0, 16'hFFFF, 0, 0, 0, 0);
        chk("r0_count", count, 0);
        idle(3);
        chk("r0_reg", dut_regs[0], 16'h0000);
        chk("r0_pending", pending[0], 1'b0);

        // Stalled burst fills the FIFO; fifth request waits for space.
        for (int i = 1; i <= 5; i++) step(1, 3'(i), 16'(16'hA000 + i), 0, 0, 0, 1);
        chk("stall_count", count, DEPTH);
        chk("stall_mem_ready", mem_ready, 1'b0);
        n = 0;
        do begin
            step(1, 5, 16'hA005, 0, 0, 0, 0);
            n++;
        end while (!last_acc && n < 20);
        chk("stall_fifth_accepted", last_acc, 1'b1);
        idle(8);
        chk("stall_reg4", dut_regs[4], 16'hA004);
        chk("stall_reg5", dut_regs[5], 16'hA005);

        // Reset in the middle of a drain.
        for (int i = 1; i <= 4; i++) step(1, 3'(i), 16'(16'hC000 + i), 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("mid_count3", count, 3);
        chk("mid_we", we, 1'b1);
        rst = 1;
        #1;
        chk("mid_rst_we", we, 1'b0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_pending", pending, 8'h00);
        chk("mid_rst_mem_ready", mem_ready, 1'b1);
        exp_q.delete();
        inflight_v = 0;
        fifo_cnt   = 0;
        idle(2);
        rst = 0;
        idle(6);
        for (int i = 1; i <= 4; i++) chk("mid_no_write", dut_regs[i], model_regs[i]);

        // Randomised traffic.
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 1), 3'($urandom), 16'($urandom),
                 $urandom_range(0, 1), 3'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        idle(10);
        chk("final_pending", pending, 8'h00);
        chk("final_queue_empty", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) chk("final_reg", dut_regs[i], model_regs[i]);
        chk("final_reg0", dut_regs[0], 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
